// File: rtl/lock_pkg.sv
// Shared types and defaults for the lock code sender.
package lock_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETUP,
    S_STROBE,
    S_GAP,
    S_WAIT,
    S_DONE
  } state_t;

  localparam int DIGIT_W_DEF    = 4;
  localparam int NUM_DIGITS_DEF = 4;

  // Combination the reference lock ships with; handy for benches.
  localparam logic [NUM_DIGITS_DEF*DIGIT_W_DEF-1:0] DEFAULT_CODE = 16'h2580;

endpackage

// File: rtl/lock_code_sender_if.sv
// Keypad-side handshake between the code sender and its user/lock.
interface lock_code_sender_if #(
  parameter int NUM_DIGITS = 4,
  parameter int DIGIT_W    = 4
);
  logic                          start;
  logic [NUM_DIGITS*DIGIT_W-1:0] code_in;
  logic                          unlocked_in;
  logic                          error_in;
  logic [DIGIT_W-1:0]            digit_out;
  logic                          enter_out;
  logic                          busy;
  logic                          done;
  logic                          pass;
  logic                          fail;
  logic                          timeout;

  modport master (
    output start, code_in, unlocked_in, error_in,
    input  digit_out, enter_out, busy, done, pass, fail, timeout
  );

  modport slave (
    input  start, code_in, unlocked_in, error_in,
    output digit_out, enter_out, busy, done, pass, fail, timeout
  );
endinterface

// File: rtl/lock_delay_counter.sv
// Loadable down-counter; expired is high while the count sits at zero.
module lock_delay_counter #(
  parameter int CNT_W = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  output logic             expired
);
  logic [CNT_W-1:0] cnt;

  // Load wins; otherwise count down and park at zero.
  always_ff @(posedge clk) begin
    if (reset)              cnt <= '0;
    else if (load)          cnt <= load_val;
    else if (cnt != '0)     cnt <= cnt - 1'b1;
  end

  assign expired = (cnt == '0);
endmodule

// File: rtl/lock_code_sender.sv
// Plays a stored combination into the lock as digit/enter strobes and
// reports pass, fail or timeout from the lock's status LEDs.
module lock_code_sender
  import lock_pkg::*;
#(
  parameter int NUM_DIGITS     = NUM_DIGITS_DEF,
  parameter int DIGIT_W        = DIGIT_W_DEF,
  parameter int GAP_CYCLES     = 2,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic             clk,
  input  logic             reset,
  lock_code_sender_if.slave bus
);
  localparam int CODE_W  = NUM_DIGITS * DIGIT_W;
  localparam int IDX_W   = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int MAX_CYC = (GAP_CYCLES > TIMEOUT_CYCLES) ? GAP_CYCLES : TIMEOUT_CYCLES;
  localparam int CNT_W   = $clog2(MAX_CYC + 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_DIGITS - 1);

  state_t             state_q, state_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [CODE_W-1:0]  code_q, code_d;
  logic [DIGIT_W-1:0] digit_q, digit_d;
  logic               enter_q, enter_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               pass_q, pass_d;
  logic               fail_q, fail_d;
  logic               tmo_q, tmo_d;
  logic               cnt_load;
  logic [CNT_W-1:0]   cnt_val;
  logic               cnt_expired;

  // Digit i counted from the most significant end of the code word.
  function automatic logic [DIGIT_W-1:0] digit_at(input logic [CODE_W-1:0] c, input int i);
    logic [CODE_W-1:0] sh;
    sh = c >> ((NUM_DIGITS - 1 - i) * DIGIT_W);
    return sh[DIGIT_W-1:0];
  endfunction

  lock_delay_counter #(.CNT_W(CNT_W)) u_delay (
    .clk      (clk),
    .reset    (reset),
    .load     (cnt_load),
    .load_val (cnt_val),
    .expired  (cnt_expired)
  );

  // Next state plus next values of every registered output.
  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    code_d   = code_q;
    digit_d  = digit_q;
    enter_d  = 1'b0;
    pass_d   = pass_q;
    fail_d   = fail_q;
    tmo_d    = tmo_q;
    cnt_load = 1'b0;
    cnt_val  = '0;
    case (state_q)
      S_IDLE: if (bus.start) begin
        code_d  = bus.code_in;
        idx_d   = '0;
        digit_d = digit_at(bus.code_in, 0);
        pass_d  = 1'b0;
        fail_d  = 1'b0;
        tmo_d   = 1'b0;
        state_d = S_SETUP;
      end
      S_SETUP: begin
        enter_d = 1'b1;
        state_d = S_STROBE;
      end
      S_STROBE: begin
        if (bus.error_in) begin
          fail_d  = 1'b1;
          state_d = S_DONE;
        end else begin
          cnt_load = 1'b1;
          cnt_val  = CNT_W'(GAP_CYCLES - 1);
          state_d  = S_GAP;
        end
      end
      S_GAP: begin
        if (bus.error_in) begin
          fail_d  = 1'b1;
          state_d = S_DONE;
        end else if (cnt_expired) begin
          if (idx_q == LAST_IDX) begin
            cnt_load = 1'b1;
            cnt_val  = CNT_W'(TIMEOUT_CYCLES - 1);
            state_d  = S_WAIT;
          end else begin
            idx_d   = idx_q + 1'b1;
            digit_d = digit_at(code_q, int'(idx_q) + 1);
            state_d = S_SETUP;
          end
        end
      end
      S_WAIT: begin
        // Error has priority over unlocked when both arrive together.
        if (bus.error_in) begin
          fail_d  = 1'b1;
          state_d = S_DONE;
        end else if (bus.unlocked_in) begin
          pass_d  = 1'b1;
          state_d = S_DONE;
        end else if (cnt_expired) begin
          fail_d  = 1'b1;
          tmo_d   = 1'b1;
          state_d = S_DONE;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    busy_d = (state_d == S_SETUP) || (state_d == S_STROBE) ||
             (state_d == S_GAP)   || (state_d == S_WAIT);
    done_d = (state_d == S_DONE);
  end

  // State and output registers; reset drops any strobe on the same edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      code_q  <= '0;
      digit_q <= '0;
      enter_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
      fail_q  <= 1'b0;
      tmo_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      code_q  <= code_d;
      digit_q <= digit_d;
      enter_q <= enter_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      pass_q  <= pass_d;
      fail_q  <= fail_d;
      tmo_q   <= tmo_d;
    end
  end

  assign bus.digit_out = digit_q;
  assign bus.enter_out = enter_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.pass      = pass_q;
  assign bus.fail      = fail_q;
  assign bus.timeout   = tmo_q;
endmodule

// File: tb/tb_lock_code_sender.sv
// Directed bench for lock_code_sender: strobe timing, results, abort, reset.
module tb_lock_code_sender;
  import lock_pkg::*;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  lock_code_sender_if #(.NUM_DIGITS(4), .DIGIT_W(4)) bus ();

  lock_code_sender #(
    .NUM_DIGITS(4), .DIGIT_W(4), .GAP_CYCLES(2), .TIMEOUT_CYCLES(16)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;
  int n_str, done_cnt, done_cyc;
  int str_cyc[8];
  logic [3:0] str_dig[8];
  logic busy_c3, busy_dn;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One attempt: start in cycle 0, lock inputs rise at the given cycles
  // (0 = never) and stay high; cycle numbers are relative to the start cycle.
  task automatic run_attempt(input logic [15:0] code, input int err_at,
                             input int unl_at, input bit spam);
    bus.code_in = code;
    bus.start   = 1'b1;
    n_str = 0; done_cnt = 0; done_cyc = -1;
    busy_c3 = 1'b0; busy_dn = 1'b1;
    for (int c = 1; c <= 40; c++) begin
      step();
      bus.start       = spam && (c <= 12) && (c % 3 == 0);
      bus.code_in     = ~code;
      bus.error_in    = (err_at > 0) && (c >= err_at);
      bus.unlocked_in = (unl_at > 0) && (c >= unl_at);
      if (bus.enter_out) begin
        if (n_str < 8) begin
          str_cyc[n_str] = c;
          str_dig[n_str] = bus.digit_out;
        end
        n_str++;
      end
      if (bus.done) begin
        done_cnt++;
        done_cyc = c;
        busy_dn  = bus.busy;
      end
      if (c == 3) busy_c3 = bus.busy;
    end
    bus.start = 1'b0;
    bus.error_in = 1'b0;
    bus.unlocked_in = 1'b0;
  endtask

  task automatic chk_result(input string t, input logic p, input logic f, input logic tm,
                            input int dcyc);
    chk({t, "_pass"},    32'(bus.pass),    32'(p));
    chk({t, "_fail"},    32'(bus.fail),    32'(f));
    chk({t, "_timeout"}, 32'(bus.timeout), 32'(tm));
    chk({t, "_done_cnt"}, 32'(done_cnt), 32'd1);
    chk({t, "_done_cyc"}, 32'(done_cyc), 32'(dcyc));
    chk({t, "_busy_end"}, 32'(bus.busy), 32'd0);
  endtask

  initial begin
    reset = 1'b1;
    bus.start = 1'b0;
    bus.code_in = '0;
    bus.error_in = 1'b0;
    bus.unlocked_in = 1'b0;
    step(); step();
    chk("reset_outs", 32'({bus.digit_out, bus.enter_out, bus.busy, bus.done,
                           bus.pass, bus.fail, bus.timeout}), 32'd0);
    reset = 1'b0;
    step();

    // 1: correct code, unlock after the 4th strobe; seen in WAIT at t+17.
    run_attempt(DEFAULT_CODE, 0, 15, 1'b0);
    chk("t1_nstr", 32'(n_str), 32'd4);
    chk("t1_cyc0", 32'(str_cyc[0]), 32'd2);
    chk("t1_cyc1", 32'(str_cyc[1]), 32'd6);
    chk("t1_cyc2", 32'(str_cyc[2]), 32'd10);
    chk("t1_cyc3", 32'(str_cyc[3]), 32'd14);
    chk("t1_digits", 32'({str_dig[0], str_dig[1], str_dig[2], str_dig[3]}), 32'h2580);
    chk("t1_busy_c3", 32'(busy_c3), 32'd1);
    chk("t1_busy_done", 32'(busy_dn), 32'd0);
    chk_result("t1", 1'b1, 1'b0, 1'b0, 18);

    // 2: wrong code, error one cycle after the 4th strobe (in GAP).
    run_attempt(16'h2581, 15, 0, 1'b0);
    chk("t2_nstr", 32'(n_str), 32'd4);
    chk("t2_last_digit", 32'(str_dig[3]), 32'h1);
    chk_result("t2", 1'b0, 1'b1, 1'b0, 16);

    // 3: error in the GAP after the 2nd strobe aborts sending.
    run_attempt(DEFAULT_CODE, 7, 0, 1'b0);
    chk("t3_nstr", 32'(n_str), 32'd2);
    chk_result("t3", 1'b0, 1'b1, 1'b0, 8);

    // 4: silent lock; WAIT runs t+17..t+32, DONE at t+33.
    run_attempt(DEFAULT_CODE, 0, 0, 1'b0);
    chk("t4_nstr", 32'(n_str), 32'd4);
    chk_result("t4", 1'b0, 1'b1, 1'b1, 33);

    // 5: both LEDs together in WAIT, error wins; extra starts ignored.
    run_attempt(DEFAULT_CODE, 17, 17, 1'b1);
    chk("t5_nstr", 32'(n_str), 32'd4);
    chk_result("t5", 1'b0, 1'b1, 1'b0, 18);

    // 6: reset during the 3rd STROBE.
    bus.code_in = DEFAULT_CODE;
    bus.start = 1'b1;
    for (int c = 1; c <= 10; c++) begin
      step();
      bus.start = 1'b0;
    end
    chk("t6_pre_enter", 32'(bus.enter_out), 32'd1);
    chk("t6_pre_digit", 32'(bus.digit_out), 32'h8);
    reset = 1'b1;
    step();
    chk("t6_enter_after_rst", 32'(bus.enter_out), 32'd0);
    chk("t6_outs_after_rst", 32'({bus.digit_out, bus.enter_out, bus.busy, bus.done,
                                  bus.pass, bus.fail, bus.timeout}), 32'd0);
    reset = 1'b0;
    step();
    run_attempt(16'h9AB3, 0, 15, 1'b0);
    chk("t6_cyc0", 32'(str_cyc[0]), 32'd2);
    chk("t6_digits", 32'({str_dig[0], str_dig[1], str_dig[2], str_dig[3]}), 32'h9AB3);
    chk_result("t6", 1'b1, 1'b0, 1'b0, 18);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/lock_code_sender.md
Name: lock_code_sender

Overview:
Transmit side of the digit/enter keypad interface used by the FSM lock. Takes a stored multi-digit combination and plays it into the lock as per-digit strobes. It then waits for the lock's status LEDs and reports pass, fail or timeout. Used as an on-chip auto-tester / remote-entry front end placed in front of the lock's ui_in path.

Parameters:
NUM_DIGITS, 4, digits per combination
DIGIT_W, 4, bits per digit (matches lock digit bus)
GAP_CYCLES, 2, idle cycles after each enter strobe (>=1)
TIMEOUT_CYCLES, 16, max cycles to wait for lock status after last gap (>=1)

Ports:
clk  in  1  single system clock, rising edge
reset  in  1  synchronous, active-high reset
start  in  1  request to send code_in; sampled only in IDLE
code_in  in  NUM_DIGITS*DIGIT_W  combination; MS digit sent first; latched on accepted start
unlocked_in  in  1  lock unlocked LED
error_in  in  1  lock error LED
digit_out  out  DIGIT_W  digit presented to lock
enter_out  out  1  one-cycle enter strobe to lock
busy  out  1  high from the cycle after start acceptance until DONE exits
done  out  1  one-cycle pulse when a result is final
pass  out  1  sticky: last attempt unlocked
fail  out  1  sticky: last attempt error or timeout
timeout  out  1  sticky: last fail was a timeout

Behaviour:
- Reset (sync, active-high): state IDLE. digit_out=0, enter_out=0, busy=0, done=0, pass=0, fail=0, timeout=0. Digit index and counters are cleared. Reset asserted mid-send drops enter_out at the same edge; no partial strobe follows.
- All outputs are registered; no combinational path from inputs to outputs.
- States: IDLE, SETUP, STROBE, GAP, WAIT, DONE.
- IDLE: if start=1, latch code_in, clear pass/fail/timeout, set index=0, and go to SETUP. start in any other state is ignored.
- SETUP (1 cycle): digit_out = digit[index], enter_out=0. Go to STROBE.
- STROBE (1 cycle): enter_out=1, digit_out held. Go to GAP.
- GAP (GAP_CYCLES cycles): enter_out=0, digit_out held. At the end of GAP:
  - if index<NUM_DIGITS-1: index++ and go to SETUP;
  - otherwise go to WAIT with the timeout counter loaded.
- Per-digit cost: 2+GAP_CYCLES cycles. Example with defaults: start high in cycle t gives SETUP at t+1, the first enter_out at t+2, the last enter_out at t+14, and WAIT starting at t+17.
- Early abort: error_in=1 seen in STROBE or GAP stops sending. Go to DONE with fail=1.
- WAIT: enter_out=0.
  - error_in=1 -> DONE, fail=1.
  - else unlocked_in=1 -> DONE, pass=1.
  - else if the counter expires after TIMEOUT_CYCLES -> DONE, fail=1, timeout=1.
  - error_in and unlocked_in both high in the same cycle: error wins.
- DONE (1 cycle): done=1, busy=0. Go to IDLE. pass/fail/timeout hold until the next accepted start or reset.
- Mutual exclusion: pass and fail are never both 1. timeout=1 implies fail=1.
- Index arithmetic: index is clog2(NUM_DIGITS) bits wide and never wraps; the last-digit compare is against NUM_DIGITS-1.
- Digit extraction: digit[i] = code_latched[(NUM_DIGITS-1-i)*DIGIT_W +: DIGIT_W].
- code_in changes after acceptance have no effect on the attempt in progress.

Decomposition:
- Shared package lock_pkg:
  - state enum for IDLE/SETUP/STROBE/GAP/WAIT/DONE;
  - DIGIT_W default;
  - NUM_DIGITS default;
  - a default combination constant for benches.
- One natural sub-module: lock_delay_counter. It is a loadable down-counter with an expire flag, reused for both GAP and WAIT timing and sized by max(GAP_CYCLES, TIMEOUT_CYCLES).

Test Plan:
1. Reset, then start with code_in=16'h2580 and the lock model unlocking after the 4th strobe. Required: enter_out pulses at t+2, t+6, t+10 and t+14, with digit_out=2,5,8,0 during each; pass=1 and a single done pulse; busy low after DONE.
2. Wrong code 16'h2581, with the lock asserting error_in 1 cycle after the 4th strobe. Required: fail=1, timeout=0, pass=0, done pulse.
3. Lock asserts error_in in the GAP after the 2nd strobe. Required: no further enter_out pulses (exactly 2 total); fail=1.
4. No status from the lock. Required: WAIT lasts 16 cycles, then fail=1, timeout=1, done=1.
5. unlocked_in and error_in both high in the same WAIT cycle -> fail=1, pass=0. Extra start pulses while busy -> ignored, exactly one attempt sent.
6. reset asserted in the cycle of the 3rd STROBE. Required: enter_out=0 next cycle and all outputs at reset values. A new start then sends digit 0 of a freshly latched code_in.
